// File: rtl/button_pkg.sv
// Shared types and defaults for the pushbutton conditioning path.
// Also provides counter-width sizing for the debounce and hold timers.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int LONG_DEFAULT     = 256;

    // Never narrower than one bit, so small parameter values still give a legal counter.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Reused for any async input that needs to enter the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_press_gen.sv
// Turns a bouncy pushbutton into registered press/release/long-press strobes,
// a debounced level and a wrapping press counter.
//
// state       | meaning
// IDLE        | button released and stable
// DEB_PRESS   | synchronized level went high, counting stable samples
// HELD        | press accepted, timing toward long_press
// DEB_RELEASE | synchronized level went low, counting stable samples
module button_press_gen
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = LONG_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             clear_cnt,
    output logic             press,
    output logic             release_p,
    output logic             long_press,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_count
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);

    logic          btn_sync;
    state_t        state;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          long_fired;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            long_fired  <= 1'b0;
            press       <= 1'b0;
            release_p   <= 1'b0;
            long_press  <= 1'b0;
            btn_level   <= 1'b0;
            press_count <= '0;
        end else begin
            press      <= 1'b0;
            release_p  <= 1'b0;
            long_press <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state <= DEB_PRESS;
                        dcnt  <= DW'(1);
                    end
                end
                DEB_PRESS: begin
                    if (!btn_sync) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else if (dcnt == D_LAST) begin
                        state       <= HELD;
                        press       <= 1'b1;
                        btn_level   <= 1'b1;
                        hcnt        <= '0;
                        press_count <= press_count + CNT_W'(1);
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state <= DEB_RELEASE;
                        dcnt  <= DW'(1);
                    end else begin
                        if (hcnt == H_LAST && !long_fired) begin
                            long_press <= 1'b1;
                            long_fired <= 1'b1;
                        end
                        if (hcnt != H_LAST) hcnt <= hcnt + HW'(1);
                    end
                end
                DEB_RELEASE: begin
                    // A short low glitch resumes the hold without losing hold time.
                    if (btn_sync) begin
                        state <= HELD;
                    end else if (dcnt == D_LAST) begin
                        state      <= IDLE;
                        release_p  <= 1'b1;
                        btn_level  <= 1'b0;
                        long_fired <= 1'b0;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a clear overrides a same-cycle increment.
            if (clear_cnt) press_count <= '0;
        end
    end

endmodule

// File: tb/tb_button_press_gen.sv
// Directed bench for button_press_gen with default parameters (D=16, LONG=256, CNT_W=8).
module tb_button_press_gen;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_raw = 1'b0;
    logic          clear_cnt = 1'b0;
    logic          press, release_p, long_press, btn_level;
    logic [CW-1:0] press_count;

    int vectors = 0;
    int miscompares = 0;

    button_press_gen #(.DEBOUNCE_CYCLES(16), .LONG_CYCLES(256), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .clear_cnt   (clear_cnt),
        .press       (press),
        .release_p   (release_p),
        .long_press  (long_press),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return press;
            1:       return release_p;
            default: return long_press;
        endcase
    endfunction

    // Number of rising edges until the selected strobe is seen; bound+1 on timeout.
    task automatic wait_sig(input int sel, input int bound, output int n);
        n = 0;
        while (n <= bound) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (sig(sel)) return;
        end
    endtask

    task automatic drive_watch(input logic b, input int cycles,
                               inout int np, inout int nr, inout int nl);
        btn_raw = b;
        repeat (cycles) begin
            @(negedge clk);
            np += int'(press);
            nr += int'(release_p);
            nl += int'(long_press);
        end
    endtask

    task automatic press_cycle();
        btn_raw = 1'b1;
        repeat (20) @(negedge clk);
        btn_raw = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n, np, nr, nl;

        repeat (3) @(negedge clk);
        chk("reset_state", {press, release_p, long_press, btn_level, press_count}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", {press, release_p, long_press, btn_level, press_count}, 0);

        // Clean press: e0 plus 17 further edges -> 18 edges to the press strobe.
        btn_raw = 1'b1;
        wait_sig(0, 40, n);
        chk("press_latency", n, 18);
        chk("press_level", btn_level, 1);
        chk("press_count_1", press_count, 1);
        chk("press_exclusive", {release_p, long_press}, 0);
        @(negedge clk);
        chk("press_one_cycle", press, 0);
        repeat (21) @(negedge clk);
        btn_raw = 1'b0;
        wait_sig(1, 40, n);
        chk("release_latency", n, 18);
        chk("release_level", btn_level, 0);
        @(negedge clk);
        chk("release_one_cycle", release_p, 0);

        // Bounce rejection.
        np = 0; nr = 0; nl = 0;
        drive_watch(1'b1, 10, np, nr, nl);
        drive_watch(1'b0, 2, np, nr, nl);
        drive_watch(1'b1, 10, np, nr, nl);
        drive_watch(1'b0, 40, np, nr, nl);
        chk("bounce_no_strobe", np + nr + nl, 0);
        chk("bounce_count", press_count, 1);
        chk("bounce_level", btn_level, 0);

        // Toggling every cycle never produces a strobe.
        np = 0; nr = 0; nl = 0;
        for (int i = 0; i < 40; i++) drive_watch(logic'(i % 2), 1, np, nr, nl);
        drive_watch(1'b0, 30, np, nr, nl);
        chk("toggle_no_strobe", np + nr + nl, 0);

        // Release glitch while held.
        btn_raw = 1'b1;
        wait_sig(0, 40, n);
        chk("glitch_press_latency", n, 18);
        np = 0; nr = 0; nl = 0;
        drive_watch(1'b1, 10, np, nr, nl);
        drive_watch(1'b0, 5, np, nr, nl);
        drive_watch(1'b1, 30, np, nr, nl);
        chk("glitch_no_press", np, 0);
        chk("glitch_no_release", nr, 0);
        chk("glitch_level", btn_level, 1);
        chk("glitch_count", press_count, 2);
        btn_raw = 1'b0;
        wait_sig(1, 40, n);
        chk("glitch_release_latency", n, 18);

        // Long press: 256 edges after the press strobe, exactly once per hold.
        btn_raw = 1'b1;
        wait_sig(0, 40, n);
        chk("long1_press_latency", n, 18);
        wait_sig(2, 300, n);
        chk("long1_latency", n, 256);
        @(negedge clk);
        chk("long1_one_cycle", long_press, 0);
        np = 0; nr = 0; nl = 0;
        drive_watch(1'b1, 120, np, nr, nl);
        chk("long1_once", nl, 0);
        btn_raw = 1'b0;
        wait_sig(1, 40, n);
        chk("long1_release_latency", n, 18);
        btn_raw = 1'b1;
        wait_sig(0, 40, n);
        chk("long2_press_latency", n, 18);
        wait_sig(2, 300, n);
        chk("long2_latency", n, 256);
        np = 0; nr = 0; nl = 0;
        drive_watch(1'b1, 20, np, nr, nl);
        btn_raw = 1'b0;
        wait_sig(1, 40, n);
        chk("long2_release_latency", n, 18);
        chk("long_count", press_count, 4);

        // Clear, wrap after 256 presses, then clear colliding with a press.
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        chk("clear_count", press_count, 0);
        for (int i = 0; i < 255; i++) press_cycle();
        chk("count_255", press_count, 255);
        press_cycle();
        chk("count_wrap", press_count, 0);
        press_cycle();
        chk("count_after_wrap", press_count, 1);
        btn_raw = 1'b1;
        repeat (17) @(negedge clk);
        clear_cnt = 1'b1;
        @(negedge clk);
        clear_cnt = 1'b0;
        chk("clear_vs_press_strobe", press, 1);
        chk("clear_vs_press_count", press_count, 0);
        btn_raw = 1'b0;
        wait_sig(1, 40, n);
        chk("clear_release_latency", n, 18);

        // Async reset mid-HELD, button still held across reset.
        btn_raw = 1'b1;
        wait_sig(0, 40, n);
        repeat (10) @(negedge clk);
        chk("pre_reset_state", {btn_level, press_count}, {1'b1, 8'd1});
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("async_reset_outputs", {press, release_p, long_press, btn_level, press_count}, 0);
        @(negedge clk);
        reset = 1'b1;
        wait_sig(0, 40, n);
        chk("post_reset_press_latency", n, 18);
        chk("post_reset_count", press_count, 1);
        btn_raw = 1'b0;
        wait_sig(1, 40, n);
        chk("post_reset_release_latency", n, 18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
